// File: rtl/riscv_mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// riscv_mem_arbiter_pkg
//   Shared definitions for the instruction/data memory arbiter.
//   - VC_MEM_REQ_MSG_SZ(a, d) : request message width
//                               (type + addr + len + data).
//   - VC_MEM_RESP_MSG_SZ(d)   : response message width (type + len + data).
//   - req_id_e                : requester IDs, which are also the values
//                               stored in the tag queue (IMEM = 0, DMEM = 1).
//   Optional feature macro used by the arbiter: RISCV_MEM_ARBITER_RR_EN.
// ---------------------------------------------------------------------------
`ifndef RISCV_MEM_ARBITER_PKG_SV
`define RISCV_MEM_ARBITER_PKG_SV

`define VC_MEM_REQ_MSG_SZ(a_, d_) (1 + (a_) + $clog2((d_) / 8) + (d_))
`define VC_MEM_RESP_MSG_SZ(d_) (1 + $clog2((d_) / 8) + (d_))

package riscv_mem_arbiter_pkg;

    typedef enum logic {
        IMEM = 1'b0,
        DMEM = 1'b1
    } req_id_e;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    // Round-robin choice when both sides request: the side that did not win last.
    function automatic req_id_e rr_other(input req_id_e last);
        return (last == IMEM) ? DMEM : IMEM;
    endfunction

endpackage

`endif

// File: rtl/riscv_mem_arbiter_tagq.sv
// ---------------------------------------------------------------------------
// riscv_mem_arbiter_tagq
//   1-bit wide, p_depth deep FIFO holding the requester ID of every memory
//   request in flight. The memory returns responses in order, so the head
//   always names the owner of the next response.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   push, push_id     : enqueue push_id (ignored when full)
//   pop               : dequeue head (ignored when empty)
//   full, empty, head : status and oldest stored ID
// ---------------------------------------------------------------------------
module riscv_mem_arbiter_tagq #(
    parameter int p_depth = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic push_id,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic head
);

    localparam int PTR_W = (p_depth > 1) ? $clog2(p_depth) : 1;
    localparam int CNT_W = $clog2(p_depth) + 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(p_depth - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(p_depth);

    logic [p_depth-1:0] slots;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic               do_push;
    logic               do_pop;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign head    = slots[rd_ptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            slots  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                slots[wr_ptr] <= push_id;
                wr_ptr        <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// ---------------------------------------------------------------------------
// riscv_mem_arbiter
//   Merges the instruction-side and data-side request streams onto one
//   memory port with zero added latency, and routes the in-order memory
//   responses back to whichever side issued the matching request.
//
//   Build option RISCV_MEM_ARBITER_RR_EN:
//     defined   : round-robin when both sides request (last_grant register)
//     undefined : fixed priority, dmem wins
//
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   imemreq_msg/val/rdy             : instruction request in
//   imemresp_msg/val                : instruction response out (no rdy)
//   dmemreq_msg/val/rdy             : data request in
//   dmemresp_msg/val                : data response out (no rdy)
//   memreq_msg/val/rdy              : shared memory request out
//   memresp_msg/val                 : shared memory response in
//   resp_err                        : sticky, response seen with nothing
//                                     outstanding; cleared only by reset
// ---------------------------------------------------------------------------
module riscv_mem_arbiter
    import riscv_mem_arbiter_pkg::*;
#(
    parameter int p_depth = 4
) (
    input  logic                                    clk,
    input  logic                                    reset,

    input  logic [`VC_MEM_REQ_MSG_SZ(32,32)-1:0]    imemreq_msg,
    input  logic                                    imemreq_val,
    output logic                                    imemreq_rdy,
    output logic [`VC_MEM_RESP_MSG_SZ(32)-1:0]      imemresp_msg,
    output logic                                    imemresp_val,

    input  logic [`VC_MEM_REQ_MSG_SZ(32,32)-1:0]    dmemreq_msg,
    input  logic                                    dmemreq_val,
    output logic                                    dmemreq_rdy,
    output logic [`VC_MEM_RESP_MSG_SZ(32)-1:0]      dmemresp_msg,
    output logic                                    dmemresp_val,

    output logic [`VC_MEM_REQ_MSG_SZ(32,32)-1:0]    memreq_msg,
    output logic                                    memreq_val,
    input  logic                                    memreq_rdy,
    input  logic [`VC_MEM_RESP_MSG_SZ(32)-1:0]      memresp_msg,
    input  logic                                    memresp_val,

    output logic                                    resp_err
);

    req_id_e grant;
    logic    full;
    logic    empty;
    logic    head;
    logic    open;
    logic    fire;
    logic    resp_in;
    logic    pop;

    // Full comes from the registered count, so a pop in the same cycle does
    // not reopen the port until the next cycle. Reset gates every handshake.
    assign open = ~full & ~reset;

`ifdef RISCV_MEM_ARBITER_RR_EN
    req_id_e last_grant;

    always_comb begin
        grant = IMEM;
        if (imemreq_val & dmemreq_val) begin
            grant = rr_other(last_grant);
        end else if (dmemreq_val) begin
            grant = DMEM;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= IMEM;
        end else if (fire) begin
            last_grant <= grant;
        end
    end
`else
    always_comb begin
        grant = dmemreq_val ? DMEM : IMEM;
    end
`endif

    assign memreq_val  = (imemreq_val | dmemreq_val) & open;
    assign memreq_msg  = (grant == DMEM) ? dmemreq_msg : imemreq_msg;
    assign imemreq_rdy = memreq_rdy & open & (grant == IMEM);
    assign dmemreq_rdy = memreq_rdy & open & (grant == DMEM);
    assign fire        = memreq_val & memreq_rdy;

    // Responses arriving while reset is held belong to a discarded history.
    assign resp_in      = memresp_val & ~reset;
    assign pop          = resp_in & ~empty;
    assign imemresp_val = pop & (req_id_e'(head) == IMEM);
    assign dmemresp_val = pop & (req_id_e'(head) == DMEM);
    assign imemresp_msg = memresp_msg;
    assign dmemresp_msg = memresp_msg;

    riscv_mem_arbiter_tagq #(
        .p_depth (p_depth)
    ) u_tagq (
        .clk     (clk),
        .reset   (reset),
        .push    (fire),
        .push_id (grant),
        .pop     (pop),
        .full    (full),
        .empty   (empty),
        .head    (head)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            resp_err <= 1'b0;
        end else if (resp_in & empty) begin
            resp_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
module tb_riscv_mem_arbiter;
    import riscv_mem_arbiter_pkg::*;

    localparam int DEPTH  = 4;
    localparam int REQ_W  = `VC_MEM_REQ_MSG_SZ(32,32);
    localparam int RESP_W = `VC_MEM_RESP_MSG_SZ(32);

    logic              clk = 1'b0;
    logic              reset;
    logic [REQ_W-1:0]  imemreq_msg, dmemreq_msg, memreq_msg;
    logic              imemreq_val, imemreq_rdy, dmemreq_val, dmemreq_rdy;
    logic [RESP_W-1:0] imemresp_msg, dmemresp_msg, memresp_msg;
    logic              imemresp_val, dmemresp_val;
    logic              memreq_val, memreq_rdy, memresp_val;
    logic              resp_err;

    always #5 clk = ~clk;

    riscv_mem_arbiter #(.p_depth(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .imemreq_msg  (imemreq_msg),
        .imemreq_val  (imemreq_val),
        .imemreq_rdy  (imemreq_rdy),
        .imemresp_msg (imemresp_msg),
        .imemresp_val (imemresp_val),
        .dmemreq_msg  (dmemreq_msg),
        .dmemreq_val  (dmemreq_val),
        .dmemreq_rdy  (dmemreq_rdy),
        .dmemresp_msg (dmemresp_msg),
        .dmemresp_val (dmemresp_val),
        .memreq_msg   (memreq_msg),
        .memreq_val   (memreq_val),
        .memreq_rdy   (memreq_rdy),
        .memresp_msg  (memresp_msg),
        .memresp_val  (memresp_val),
        .resp_err     (resp_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Scoreboard: requester ID expected for each outstanding response.
    logic sb_q[$];
    logic mdl_err  = 1'b0;
    logic mdl_last = 1'b0;
    logic [31:0] iaddr = 32'h0000_1000;
    logic [31:0] daddr = 32'h8000_0000;
    logic grant_log[$];
    logic resp_log[$];

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [REQ_W-1:0] mk_req(input logic typ, input logic [31:0] addr,
                                                input logic [31:0] data);
        return {typ, addr, 2'b00, data};
    endfunction

    // One bench cycle: drive inputs, check combinational outputs against the
    // model, then advance the model across the rising edge.
    task automatic cyc(input logic iv, input logic dv, input logic mrdy,
                       input logic rv, input logic rst);
        logic full_m, g_d, exp_mval, exp_pop, hd, fire_m, was_empty;
        imemreq_val = iv;
        dmemreq_val = dv;
        memreq_rdy  = mrdy;
        memresp_val = rv;
        reset       = rst;
        imemreq_msg = mk_req(1'b0, iaddr, $urandom);
        dmemreq_msg = mk_req(1'b1, daddr, $urandom);
        memresp_msg = RESP_W'({$urandom, $urandom});
        #2;
        full_m = (sb_q.size() == DEPTH);
`ifdef RISCV_MEM_ARBITER_RR_EN
        g_d = (iv && dv) ? (mdl_last == 1'b0) : dv;
`else
        g_d = dv;
`endif
        exp_mval = (iv | dv) & ~full_m & ~rst;
        chk("memreq_val", memreq_val, exp_mval);
        if (exp_mval) chk("memreq_msg", memreq_msg, g_d ? dmemreq_msg : imemreq_msg);
        chk("imemreq_rdy", imemreq_rdy, mrdy & ~full_m & ~rst & ~g_d);
        chk("dmemreq_rdy", dmemreq_rdy, mrdy & ~full_m & ~rst & g_d);
        exp_pop = rv & ~rst & (sb_q.size() > 0);
        hd = (sb_q.size() > 0) ? sb_q[0] : 1'b0;
        chk("imemresp_val", imemresp_val, exp_pop & ~hd);
        chk("dmemresp_val", dmemresp_val, exp_pop & hd);
        if (exp_pop) begin
            chk("imemresp_msg", imemresp_msg, memresp_msg);
            chk("dmemresp_msg", dmemresp_msg, memresp_msg);
        end
        chk("resp_err", resp_err, mdl_err);
        fire_m = exp_mval & mrdy;
        if (memreq_val && memreq_rdy) grant_log.push_back(memreq_msg == dmemreq_msg);
        if (imemresp_val) resp_log.push_back(1'b0);
        if (dmemresp_val) resp_log.push_back(1'b1);
        @(posedge clk);
        if (rst) begin
            sb_q.delete();
            mdl_err  = 1'b0;
            mdl_last = 1'b0;
        end else begin
            was_empty = (sb_q.size() == 0);
            if (exp_pop) void'(sb_q.pop_front());
            if (fire_m) begin
                sb_q.push_back(g_d);
                mdl_last = g_d;
            end
            if (rv && was_empty) mdl_err = 1'b1;
        end
        if (fire_m && !g_d) iaddr = iaddr + 32'd4;
        if (fire_m && g_d)  daddr = daddr + 32'd4;
        #1;
    endtask

    initial begin
        logic exp_g[4];
        logic exp_r[4];
        reset = 1'b1;
        imemreq_val = 1'b0; dmemreq_val = 1'b0; memreq_rdy = 1'b0; memresp_val = 1'b0;
        imemreq_msg = '0; dmemreq_msg = '0; memresp_msg = '0;
        @(posedge clk); #1;

        // Reset: everything quiet even with all inputs active.
        cyc(1, 1, 1, 1, 1);
        cyc(1, 1, 1, 1, 1);

        // Single imem request at 0x1000, response two cycles later.
        iaddr = 32'h0000_1000;
        cyc(1, 0, 1, 0, 0);
        chk("req030_addr", grant_log.size() > 0 ? 1'b1 : 1'b0, 1'b1);
        cyc(0, 0, 1, 0, 0);
        resp_log.delete();
        cyc(0, 0, 1, 1, 0);
        chk("req030_side", resp_log.size() == 1 ? {31'd0, resp_log[0]} : 32'hdead, 32'd0);

        // Both valid for 4 fires, no responses: grant pattern, then full.
        grant_log.delete();
        repeat (4) cyc(1, 1, 1, 0, 0);
`ifdef RISCV_MEM_ARBITER_RR_EN
        exp_g = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_g = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        chk("grant_cnt", grant_log.size(), 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("grant%0d", i), (i < grant_log.size()) ? grant_log[i] : 1'bx, exp_g[i]);
        cyc(1, 1, 1, 0, 0);      // full: blocked
        cyc(1, 1, 1, 1, 0);      // response routed, request still blocked
        repeat (3) cyc(0, 0, 1, 1, 0);

        // Interleaved I,D,D,I with responses 3 cycles after each fire.
        resp_log.delete();
        cyc(1, 0, 1, 0, 0);
        cyc(0, 1, 1, 0, 0);
        cyc(0, 1, 1, 0, 0);
        cyc(1, 0, 1, 1, 0);
        repeat (3) cyc(0, 0, 1, 1, 0);
        exp_r = '{1'b0, 1'b1, 1'b1, 1'b0};
        chk("order_cnt", resp_log.size(), 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("order%0d", i), (i < resp_log.size()) ? resp_log[i] : 1'bx, exp_r[i]);

        // Stray response: sticky error until reset.
        cyc(0, 0, 1, 1, 0);
        repeat (3) cyc(1, 0, 0, 0, 0);
        chk("err_held", resp_err, 1'b1);
        cyc(0, 0, 0, 0, 1);
        chk("err_clr", resp_err, 1'b0);

        // Reset with 3 outstanding, then a late response is an error.
        repeat (3) cyc(0, 1, 1, 0, 0);
        cyc(0, 0, 1, 1, 1);
        cyc(0, 0, 1, 1, 0);
        chk("late_err", resp_err, 1'b1);
        repeat (4) cyc(1, 0, 1, 0, 0);   // queue was emptied: four accepted
        cyc(1, 0, 1, 0, 0);              // now full
        repeat (4) cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1);

        // Random traffic, responses only while something is outstanding.
        for (int i = 0; i < 300; i++) begin
            cyc($urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 3) != 0),
                (sb_q.size() > 0) && ($urandom_range(0, 2) != 0), 1'b0);
        end
        while (sb_q.size() > 0) cyc(0, 0, 0, 1, 0);
        chk("final_err", resp_err, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
